scroll_bg_renderer: RTL and testbench

//  Pipelined, parametrised background renderer: maps VGA (DrawX, DrawY) to a SRC_W x SRC_H indexed-colour ROM.

---
 rtl/scroll_bg_renderer.sv | 136 +++++++++++++
 tb/tb_scroll_bg_renderer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/scroll_bg_renderer.sv
// Pipelined scrolling background renderer: VGA (DrawX, DrawY) -> upscaled, wrapped ROM address,
// then registered palette colour with a transparency flag. Offsets only change at the frame boundary.
module scroll_bg_renderer #(
    parameter int SRC_W       = 320,
    parameter int SRC_H       = 240,
    parameter int SCALE_SHIFT = 1,
    parameter int IDX_W       = 4,
    parameter int V_ACTIVE    = 480,
    parameter int TRANS_INDEX = 0,
    parameter int ADDR_W      = $clog2(SRC_W * SRC_H),
    parameter int XW          = $clog2(SRC_W),
    parameter int YW          = $clog2(SRC_H)
) (
    input  logic              vga_clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [XW-1:0]     scroll_x,
    input  logic [YW-1:0]     scroll_y,
    input  logic              scroll_ld,
    input  logic              auto_en,
    input  logic [XW-1:0]     auto_step,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    input  logic [11:0]       pal_rgb,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              opaque
);

    localparam int MW = (XW > YW) ? XW : YW;
    localparam int CW = ((MW > 10) ? MW : 10) + 1;
    localparam logic [31:0] SRC_W_U = 32'(SRC_W);
    localparam logic [31:0] SRC_H_U = 32'(SRC_H);

    logic [XW-1:0]     off_x_q, off_x_d, shx_q, shx_d;
    logic [YW-1:0]     off_y_q, off_y_d, shy_q, shy_d;
    logic              pend_q, pend_d;
    logic              v1_q, v2_q;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [11:0]       rgb_q, rgb_d;
    logic              opaque_q, opaque_d;

    logic              fb;
    logic [CW-1:0]     sx_sum, sy_sum, sx, sy, ax_sum, ax_wrap;
    logic [XW-1:0]     step_eff, ld_x;
    logic [YW-1:0]     ld_y;

    assign fb = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));

    // Both addends are below the source size in the visible region, so one subtract wraps.
    always_comb begin
        sx_sum     = CW'(DrawX >> SCALE_SHIFT) + CW'(off_x_q);
        sy_sum     = CW'(DrawY >> SCALE_SHIFT) + CW'(off_y_q);
        sx         = (sx_sum >= CW'(SRC_W)) ? sx_sum - CW'(SRC_W) : sx_sum;
        sy         = (sy_sum >= CW'(SRC_H)) ? sy_sum - CW'(SRC_H) : sy_sum;
        rom_addr_d = blank ? (ADDR_W'(sy) * ADDR_W'(SRC_W) + ADDR_W'(sx)) : '0;
    end

    always_comb begin
        step_eff = (32'(auto_step) >= SRC_W_U) ? '0 : auto_step;
        ld_x     = (32'(scroll_x) >= SRC_W_U) ? '0 : scroll_x;
        ld_y     = (32'(scroll_y) >= SRC_H_U) ? '0 : scroll_y;
        ax_sum   = CW'(off_x_q) + CW'(step_eff);
        ax_wrap  = (ax_sum >= CW'(SRC_W)) ? ax_sum - CW'(SRC_W) : ax_sum;
    end

    // A load in the fb cycle re-arms pending for the following boundary.
    always_comb begin
        off_x_d = off_x_q;
        off_y_d = off_y_q;
        pend_d  = pend_q;
        shx_d   = shx_q;
        shy_d   = shy_q;
        if (fb) begin
            if (pend_q) begin
                off_x_d = shx_q;
                off_y_d = shy_q;
                pend_d  = 1'b0;
            end else if (auto_en) begin
                off_x_d = XW'(ax_wrap);
            end
        end
        if (scroll_ld) begin
            shx_d  = ld_x;
            shy_d  = ld_y;
            pend_d = 1'b1;
        end
    end

    always_comb begin
        rgb_d    = v2_q ? pal_rgb : '0;
        opaque_d = v2_q && (rom_q != IDX_W'(TRANS_INDEX));
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            off_x_q <= '0;
            off_y_q <= '0;
            shx_q   <= '0;
            shy_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            off_x_q <= off_x_d;
            off_y_q <= off_y_d;
            shx_q   <= shx_d;
            shy_q   <= shy_d;
            pend_q  <= pend_d;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            rom_addr_q <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            rgb_q      <= '0;
            opaque_q   <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            v1_q       <= blank;
            v2_q       <= v1_q;
            rgb_q      <= rgb_d;
            opaque_q   <= opaque_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign red      = rgb_q[11:8];
    assign green    = rgb_q[7:4];
    assign blue     = rgb_q[3:0];
    assign opaque   = opaque_q;

endmodule

// File: tb/tb_scroll_bg_renderer.sv
// Randomized bench for scroll_bg_renderer: a sync-read ROM and palette model feed the DUT, and a
// frame-level reference model (offsets, pending load, 3-cycle output latency) predicts every cycle.
module tb_scroll_bg_renderer;

    localparam int SW = 320;
    localparam int SH = 240;

    logic        vga_clk;
    logic        Reset;
    logic [9:0]  DrawX, DrawY;
    logic        blank;
    logic [8:0]  scroll_x;
    logic [7:0]  scroll_y;
    logic        scroll_ld;
    logic        auto_en;
    logic [8:0]  auto_step;
    logic [16:0] rom_addr;
    logic [3:0]  rom_q;
    logic [11:0] pal_rgb;
    logic [3:0]  red, green, blue;
    logic        opaque;

    logic [3:0]  rom [0:SW*SH-1];
    logic [11:0] pal [0:15];

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int       offx, offy, shx, shy;
    bit       pend;
    logic [12:0] p1, p2;
    bit       r1;

    scroll_bg_renderer #(
        .SRC_W(SW), .SRC_H(SH), .SCALE_SHIFT(1), .IDX_W(4), .V_ACTIVE(480), .TRANS_INDEX(0)
    ) dut (
        .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .scroll_x(scroll_x), .scroll_y(scroll_y), .scroll_ld(scroll_ld),
        .auto_en(auto_en), .auto_step(auto_step), .rom_addr(rom_addr), .rom_q(rom_q),
        .pal_rgb(pal_rgb), .red(red), .green(green), .blue(blue), .opaque(opaque)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) rom_q <= rom[rom_addr];
    assign pal_rgb = pal[rom_q];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, want, $time);
        end
    endtask

    // One pixel clock: drive inputs, predict, clock, compare, then advance the model.
    task automatic step(input int x, input int y, input bit bl, input bit ld,
                        input int lx, input int ly, input bit rst);
        int          ea;
        int          idx;
        int          st;
        logic [12:0] pix, eo;
        DrawX     = 10'(x);
        DrawY     = 10'(y);
        blank     = bl;
        scroll_ld = ld;
        scroll_x  = 9'(lx);
        scroll_y  = 8'(ly);
        Reset     = rst;
        if (rst || !bl) begin
            ea  = 0;
            pix = '0;
        end else begin
            ea  = (((y >> 1) + offy) % SH) * SW + (((x >> 1) + offx) % SW);
            idx = int'(rom[ea]);
            pix = {pal[idx], idx != 0};
        end
        @(posedge vga_clk);
        #1;
        eo = (rst || r1) ? 13'd0 : p2;
        check("rom_addr", 32'(rom_addr), 32'(ea));
        check("pixel", 32'({red, green, blue, opaque}), 32'(eo));
        p2 = p1;
        p1 = pix;
        r1 = rst;
        if (rst) begin
            offx = 0; offy = 0; shx = 0; shy = 0; pend = 0;
        end else begin
            if (x == 0 && y == 480) begin
                if (pend) begin
                    offx = shx; offy = shy; pend = 0;
                end else if (auto_en) begin
                    st   = (int'(auto_step) >= SW) ? 0 : int'(auto_step);
                    offx = (offx + st) % SW;
                end
            end
            if (ld) begin
                shx  = (int'(scroll_x) >= SW) ? 0 : int'(scroll_x);
                shy  = (int'(scroll_y) >= SH) ? 0 : int'(scroll_y);
                pend = 1;
            end
        end
    endtask

    task automatic pixel(input int x, input int y);
        step(x, y, 1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic frame_edge();
        step(0, 480, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic load(input int lx, input int ly);
        step(600, 490, 1'b0, 1'b1, lx, ly, 1'b0);
    endtask

    initial begin
        int r, x, y;
        bit bl, ld;
        for (int i = 0; i < SW*SH; i++) rom[i] = 4'($urandom);
        for (int i = 0; i < 16; i++) pal[i] = 12'($urandom);
        rom[5]   = 4'd5;
        rom[100] = 4'd0;
        pal[5]   = 12'hABC;
        offx = 0; offy = 0; shx = 0; shy = 0; pend = 0;
        p1 = '0; p2 = '0; r1 = 1;
        auto_en = 1'b0;
        auto_step = '0;

        step(0, 0, 1'b1, 1'b0, 0, 0, 1'b1);
        step(0, 0, 1'b1, 1'b0, 0, 0, 1'b1);
        check("reset_addr", 32'(rom_addr), 32'd0);
        check("reset_pixel", 32'({red, green, blue, opaque}), 32'd0);

        pixel(0, 0);
        pixel(1, 0);
        check("addr_x1", 32'(rom_addr), 32'd0);
        pixel(2, 0);
        check("addr_x2", 32'(rom_addr), 32'd1);
        pixel(3, 0);

        pixel(10, 0);
        pixel(11, 0);
        pixel(12, 0);
        check("latency_abc", 32'({red, green, blue, opaque}), 32'h1579);

        load(319, 10);
        frame_edge();
        pixel(2, 479);
        check("wrap_addr", 32'(rom_addr), 32'd2880);

        step(5, 100, 1'b1, 1'b1, 40, 0, 1'b0);
        pixel(0, 0);
        check("ld_hold", 32'(rom_addr), 32'd3519);
        frame_edge();
        pixel(0, 0);
        check("ld_apply", 32'(rom_addr), 32'd40);

        load(318, 0);
        frame_edge();
        auto_en = 1'b1;
        auto_step = 9'd4;
        frame_edge();
        pixel(0, 0);
        check("auto_wrap", 32'(rom_addr), 32'd2);
        load(7, 0);
        frame_edge();
        pixel(0, 0);
        check("ld_beats_auto", 32'(rom_addr), 32'd7);
        step(0, 480, 1'b0, 1'b1, 50, 0, 1'b0);
        pixel(0, 0);
        check("ld_at_fb_defer", 32'(rom_addr), 32'd11);
        frame_edge();
        pixel(0, 0);
        check("ld_at_fb_next", 32'(rom_addr), 32'd50);

        auto_en = 1'b0;
        load(0, 0);
        frame_edge();
        pixel(200, 0);
        pixel(201, 0);
        pixel(202, 0);
        check("transparent", 32'({red, green, blue, opaque}), 32'({pal[0], 1'b0}));
        step(200, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        check("blank_addr", 32'(rom_addr), 32'd0);
        pixel(1, 1);
        pixel(2, 1);
        check("blank_pixel", 32'({red, green, blue, opaque}), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                auto_en   = 1'($urandom_range(0, 1));
                auto_step = 9'($urandom_range(0, 511));
            end
            r  = $urandom_range(0, 199);
            ld = ($urandom_range(0, 15) == 0);
            if (r < 4) begin
                step(0, 480, 1'b0, ld, $urandom_range(0, 511), $urandom_range(0, 255), 1'b0);
            end else if (r < 5) begin
                step(0, 0, 1'b1, 1'b0, 0, 0, 1'b1);
            end else begin
                bl = ($urandom_range(0, 4) != 0);
                x  = bl ? $urandom_range(0, 639) : $urandom_range(0, 799);
                y  = bl ? $urandom_range(0, 479) : $urandom_range(0, 524);
                step(x, y, bl, ld, $urandom_range(0, 511), $urandom_range(0, 255), 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
